keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad scanner for the board's 4x4 keypad. It is the input-side counterpart of the multiplexed 7-segment display driver: it drives one keypad row low at a time and samples the four column lines. It debounces the full 16-key state across whole scan frames and emits a one-cycle key event with a 4-bit key code. It runs on the same 1 kHz scan clock as the display driver, and its key codes feed the display and control logic.

## Interface
- DWELL, 4: clock cycles each row is driven; legal range 3..15.
- DEBOUNCE_SCANS, 4: consecutive identical frames required before the debounced map updates; legal range 2..7.
- clk_1K  input  1  scan clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- col  input  4  keypad column lines, active-low, externally pulled up, asynchronous to clk_1K.
- row  output  4  keypad row drive, active-low one-hot; bit r drives row r.
- key_map  output  16  debounced key state; bit (4*r + c) = 1 means key (row r, col c) is pressed.
- key_code  output  4  index 4*r + c of the last key event; holds its value between events.
- key_valid  output  1  one-cycle pulse marking a new single-key press.
- key_held  output  1  1 while key_map is nonzero.

## Operation
- Synchronizer: col passes through 2 flops. col_s = ~(second flop), so 1 = pressed.
- Row sequencer:
  - row_idx (2 bits) and dwell_cnt (0..DWELL-1).
  - row = ~(4'b0001 << row_idx).
  - dwell_cnt increments each cycle; on DWELL-1 it wraps to 0 and row_idx increments, wrapping 3 -> 0.
- Sampling:
  - On the cycle where dwell_cnt = DWELL-1, col_s is written into raw[4*row_idx +: 4].
  - DWELL >= 3 ensures col_s reflects the currently driven row by then.
- Frame end is the sampling edge with row_idx = 3. On that edge:
  - frame = raw with the row-3 nibble replaced by the value being sampled.
  - If frame == prev_frame: stable_cnt = min(stable_cnt+1, DEBOUNCE_SCANS-1). Otherwise stable_cnt = 0.
  - prev_frame <= frame.
  - If the updated stable_cnt == DEBOUNCE_SCANS-1, key_map <= frame.
- Event rule:
  - key_valid pulses on the edge key_map changes from all-zero to exactly one bit set.
  - On that same edge, key_code <= index of that bit.
- No event for:
  - multi-key maps;
  - one-hot to one-hot changes without passing through zero;
  - transitions from a multi-key map to a single key.
- key_held = |key_map, registered together with key_map.
- Release: key_map returns to zero only after DEBOUNCE_SCANS identical all-zero frames.
- Ghosting: no anti-ghost masking; key_map reports whatever the matrix reads.
- Reset values (async assert, applied immediately):
  - row = 4'b1110; row_idx = 0; dwell_cnt = 0.
  - synchronizer flops = 4'b1111 (released).
  - raw, prev_frame, key_map = 0; stable_cnt = 0.
  - key_code = 0; key_valid = 0; key_held = 0.

## Timing
- Frame length: 4*DWELL cycles; defaults give 16 cycles = 16 ms.
- Input to col_s: 2 cycles.
- Press latency: press stable before a frame starts -> key_map/key_valid update at the end of the DEBOUNCE_SCANS-th full frame. Defaults: 64 cycles after that frame start, plus up to one frame of alignment.
- key_valid: high exactly one cycle, on the frame-end edge; key_code is valid on that cycle.
- Bounce: any change inside a frame alters that frame's nibble and restarts stable_cnt at the next frame end.
- Reset mid-operation:
  - Outputs are cleared immediately and scanning restarts at row 0.
  - A key held through reset is re-detected and produces a fresh key_valid after debounce.
- row changes only on the edge after dwell_cnt = DWELL-1; no glitches on row.

## Test plan
- Reset: rst_n low mid-scan -> row = 4'b1110, key_map = 0, key_valid = 0 immediately. Release, press nothing for 10 frames -> row sequence 1110, 1101, 1011, 0111, each held 4 cycles, key_valid never asserts.
- Single press: model pulls col[1] low only while row[2] is low, stable for 6 frames -> key_map = 16'h0200, one key_valid pulse with key_code = 9, key_held = 1. After release, key_held drops after 4 zero frames; no pulse on release.
- Bounce: key (0,0) toggles every 5 cycles for 3 frames, then holds -> no key_valid until 4 stable frames after the toggling ends, then key_code = 0, exactly one pulse.
- Multi-key: keys 5 and 10 pressed together -> key_map = 16'h0420, key_valid stays 0. Release key 10 only -> key_map = 16'h0020, still no pulse. Release all, then press 15 -> pulse with key_code = 15.
- Corner key and wrap: press (3,3) -> key_code = 15. Confirm row_idx wraps 3 -> 0 and the frame-end update lands on the row-3 sampling edge.
- Reset during held key: key 6 held with key_map = 16'h0040; assert rst_n low for 3 cycles -> key_map = 0. After release of rst_n, a new pulse with key_code = 6 arrives after 4 frames.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix-keypad scanner: row sequencing, column synchronization,
// whole-frame debouncing and single-key press events.
module keypad_scan #(
    parameter int unsigned DWELL          = 4,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk_1K,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] key_map,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam int unsigned DW_W = 4;
    localparam int unsigned ST_W = 3;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [ST_W-1:0] STABLE_MAX = ST_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]      col_q1;
    logic [3:0]      col_q2;
    logic [3:0]      col_s;
    logic [1:0]      row_idx;
    logic [1:0]      row_idx_next;
    logic [DW_W-1:0] dwell_cnt;
    logic [15:0]     raw;
    logic [15:0]     prev_frame;
    logic [ST_W-1:0] stable_cnt;
    logic [ST_W-1:0] stable_next;
    logic [15:0]     frame;
    logic [3:0]      frame_idx;
    logic            sample;
    logic            frame_end;
    logic            update;
    logic            frame_onehot;

    // Two-flop synchronizer; columns idle high, so reset to released.
    always_ff @(posedge clk_1K or negedge rst_n) begin
        if (!rst_n) begin
            col_q1 <= 4'hF;
            col_q2 <= 4'hF;
        end else begin
            col_q1 <= col;
            col_q2 <= col_q1;
        end
    end

    // Frame-end decode, debounce counter update and single-key detection.
    always_comb begin
        col_s        = ~col_q2;
        sample       = (dwell_cnt == DWELL_LAST);
        frame_end    = sample && (row_idx == 2'd3);
        row_idx_next = row_idx + 2'd1;
        frame        = {col_s, raw[11:0]};
        stable_next  = '0;
        if (frame == prev_frame) begin
            stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + ST_W'(1);
        end
        update       = frame_end && (stable_next == STABLE_MAX);
        frame_onehot = (frame != 16'd0) && ((frame & (frame - 16'd1)) == 16'd0);
        frame_idx    = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (frame[i]) begin
                frame_idx = 4'(i);
            end
        end
    end

    // Row sequencer: each row is driven low for DWELL cycles, then the next.
    always_ff @(posedge clk_1K or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            row_idx   <= '0;
            row       <= 4'b1110;
        end else if (sample) begin
            dwell_cnt <= '0;
            row_idx   <= row_idx_next;
            row       <= ~(4'b0001 << row_idx_next);
        end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
        end
    end

    // Capture the column nibble of the driven row at the end of its dwell.
    always_ff @(posedge clk_1K or negedge rst_n) begin
        if (!rst_n) begin
            raw <= '0;
        end else if (sample) begin
            raw[4*row_idx +: 4] <= col_s;
        end
    end

    // Whole-frame debounce: key_map follows only a run of identical frames.
    always_ff @(posedge clk_1K or negedge rst_n) begin
        if (!rst_n) begin
            prev_frame <= '0;
            stable_cnt <= '0;
            key_map    <= '0;
            key_held   <= 1'b0;
        end else if (frame_end) begin
            prev_frame <= frame;
            stable_cnt <= stable_next;
            if (update) begin
                key_map  <= frame;
                key_held <= |frame;
            end
        end
    end

    // Press event only for an idle map becoming a single key.
    always_ff @(posedge clk_1K or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (update && (key_map == 16'd0) && frame_onehot) begin
                key_valid <= 1'b1;
                key_code  <= frame_idx;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a resistive-matrix keypad model.
module tb_keypad_scan;

    logic        clk_1K;
    logic        rst_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] key_map;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int n_cmp;
    int n_err;

    keypad_scan #(.DWELL(4), .DEBOUNCE_SCANS(4)) dut (
        .clk_1K    (clk_1K),
        .rst_n     (rst_n),
        .col       (col),
        .row       (row),
        .key_map   (key_map),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk_1K = 1'b0;
    always #5 clk_1K = ~clk_1K;

    // A pressed key shorts its column to its row when that row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys[4*r + c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    // Stop at the negedge right after row 0 is re-driven (start of a frame).
    task automatic align_frame();
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = row;
            @(negedge clk_1K);
            if (row == 4'b1110 && prev == 4'b0111) found = 1'b1;
        end
        n_cmp++;
        if (found !== 1'b1) begin
            n_err++;
            $display("FAIL align_frame: frame start seen=%0b required=1", found);
        end
    endtask

    // Observe n cycles, recording press pulses and the key_held fall time.
    task automatic watch(input int n, output int pulses, output int first_pulse,
                         output logic [3:0] code, output logic [3:0] row_at_pulse,
                         output int held_fall);
        pulses       = 0;
        first_pulse  = -1;
        code         = 4'h0;
        row_at_pulse = 4'h0;
        held_fall    = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_1K);
            if (key_valid) begin
                pulses++;
                if (first_pulse < 0) begin
                    first_pulse  = i;
                    row_at_pulse = row;
                end
                code = key_code;
            end
            if (!key_held && held_fall < 0) held_fall = i;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        keys  = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_1K);
        rst_n = 1'b1;
        repeat (7) @(negedge clk_1K);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (row !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_row: got=%b exp=1110", row);
        end
        n_cmp++;
        if (key_map !== 16'h0000 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            n_err++;
            $display("FAIL reset_outputs: map=%h valid=%b held=%b code=%h exp=0000/0/0/0",
                     key_map, key_valid, key_held, key_code);
        end
        @(negedge clk_1K);
        rst_n = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            @(negedge clk_1K);
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            n_cmp++;
            if (row !== exp_row) begin
                n_err++;
                $display("FAIL idle_row cycle %0d: got=%b exp=%b", i, row, exp_row);
            end
            n_cmp++;
            if (key_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_valid cycle %0d: got=%b exp=0", i, key_valid);
            end
        end
    endtask

    task automatic test_single_press();
        int pulses, first, fall;
        logic [3:0] code, prow;
        align_frame();
        keys = 16'h0200;
        watch(96, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 1 || first !== 64 || code !== 4'd9) begin
            n_err++;
            $display("FAIL press9: pulses=%0d at=%0d code=%0d exp=1/64/9", pulses, first, code);
        end
        n_cmp++;
        if (key_map !== 16'h0200 || key_held !== 1'b1) begin
            n_err++;
            $display("FAIL press9_map: map=%h held=%b exp=0200/1", key_map, key_held);
        end
        align_frame();
        keys = 16'h0000;
        watch(96, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 0 || fall !== 64) begin
            n_err++;
            $display("FAIL release9: pulses=%0d held_fall=%0d exp=0/64", pulses, fall);
        end
        n_cmp++;
        if (key_map !== 16'h0000 || key_held !== 1'b0) begin
            n_err++;
            $display("FAIL release9_map: map=%h held=%b exp=0000/0", key_map, key_held);
        end
    endtask

    task automatic test_bounce();
        int pulses, first;
        logic [3:0] code;
        pulses = 0;
        first  = -1;
        code   = 4'h0;
        align_frame();
        for (int i = 0; i < 130; i++) begin
            keys = (i >= 48 || ((i / 5) % 2) == 0) ? 16'h0001 : 16'h0000;
            @(negedge clk_1K);
            if (key_valid) begin
                pulses++;
                if (first < 0) first = i + 1;
                code = key_code;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 96 || code !== 4'd0) begin
            n_err++;
            $display("FAIL bounce: pulses=%0d at=%0d code=%0d exp=1/96/0", pulses, first, code);
        end
        n_cmp++;
        if (key_map !== 16'h0001) begin
            n_err++;
            $display("FAIL bounce_map: got=%h exp=0001", key_map);
        end
        keys = 16'h0000;
        repeat (96) @(negedge clk_1K);
    endtask

    task automatic test_multi_key();
        int pulses, first, fall;
        logic [3:0] code, prow;
        align_frame();
        keys = 16'h0420;
        watch(80, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 0 || key_map !== 16'h0420) begin
            n_err++;
            $display("FAIL multi: pulses=%0d map=%h exp=0/0420", pulses, key_map);
        end
        keys = 16'h0020;
        watch(80, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 0 || key_map !== 16'h0020) begin
            n_err++;
            $display("FAIL multi_to_single: pulses=%0d map=%h exp=0/0020", pulses, key_map);
        end
        keys = 16'h0000;
        watch(80, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 0 || key_map !== 16'h0000) begin
            n_err++;
            $display("FAIL multi_release: pulses=%0d map=%h exp=0/0000", pulses, key_map);
        end
    endtask

    task automatic test_corner_wrap();
        int pulses, first, fall;
        logic [3:0] code, prow;
        align_frame();
        keys = 16'h8000;
        watch(80, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 1 || first !== 64 || code !== 4'd15) begin
            n_err++;
            $display("FAIL corner15: pulses=%0d at=%0d code=%0d exp=1/64/15", pulses, first, code);
        end
        n_cmp++;
        if (prow !== 4'b1110) begin
            n_err++;
            $display("FAIL corner_wrap_row: row at pulse=%b exp=1110", prow);
        end
        keys = 16'h0000;
        repeat (96) @(negedge clk_1K);
    endtask

    task automatic test_reset_held();
        int pulses, first, fall;
        logic [3:0] code, prow;
        align_frame();
        keys = 16'h0040;
        watch(80, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 1 || key_map !== 16'h0040 || code !== 4'd6) begin
            n_err++;
            $display("FAIL held6: pulses=%0d map=%h code=%0d exp=1/0040/6", pulses, key_map, code);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (key_map !== 16'h0000 || key_held !== 1'b0 || key_code !== 4'h0 || row !== 4'b1110) begin
            n_err++;
            $display("FAIL held_reset: map=%h held=%b code=%h row=%b exp=0000/0/0/1110",
                     key_map, key_held, key_code, row);
        end
        repeat (3) @(negedge clk_1K);
        rst_n = 1'b1;
        watch(90, pulses, first, code, prow, fall);
        n_cmp++;
        if (pulses !== 1 || first !== 64 || code !== 4'd6) begin
            n_err++;
            $display("FAIL redetect6: pulses=%0d at=%0d code=%0d exp=1/64/6", pulses, first, code);
        end
        keys = 16'h0000;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        keys  = 16'h0000;
        rst_n = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_corner_wrap();
        test_reset_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
